// File: rtl/uart_loader_if.sv
// APB master port toward the UART controller plus the memory write port
// used by the boot loader. The loader takes the master modport.
interface uart_loader_if;
  logic [3:0]  apb_PADDR;
  logic        apb_PSEL;
  logic        apb_PENABLE;
  logic        apb_PWRITE;
  logic [31:0] apb_PWDATA;
  logic        apb_PREADY;
  logic [31:0] apb_PRDATA;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (
    output apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA,
    input  apb_PREADY, apb_PRDATA,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready
  );

  modport slave (
    input  apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA,
    output apb_PREADY, apb_PRDATA,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready
  );
endinterface

// File: rtl/uart_loader.sv
// Boot loader: programs the UART divisor, receives a framed packet
// (magic, address, length, payload) over APB, writes the payload to memory
// as 32-bit words and replies with ACK + 8-bit checksum.
// Handshakes: APB transfer = setup (PSEL, !PENABLE) then access cycles
// until PREADY; memory request transfers on the cycle mem_valid & mem_ready.
module uart_loader #(
  parameter logic [15:0] DIVISOR = 16'd9,
  parameter logic [7:0]  MAGIC   = 8'h4C,
  parameter logic [7:0]  ACK     = 8'h4B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rx_error,
  output logic [31:0] entry_addr,
  output logic [3:0]  dbg_state,
  uart_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CONF   = 4'd1,
    S_MAGIC  = 4'd2,
    S_HDR    = 4'd3,
    S_DATA   = 4'd4,
    S_MEMWR  = 4'd5,
    S_TXPOLL = 4'd6,
    S_TXWR   = 4'd7,
    S_DONE   = 4'd8,
    S_ERRCLR = 4'd9
  } state_t;

  state_t      state, state_nxt;
  logic        apb_phase;
  logic        apb_active;
  logic        xfer_done;
  logic        rx_state;
  logic        rx_ok, rx_bad;
  logic [7:0]  rx_byte;
  logic [2:0]  hdr_cnt;
  logic [31:0] hdr_addr;
  logic [31:0] hdr_len;
  logic [31:0] remain;
  logic [31:0] wr_addr;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  lane;
  logic [7:0]  csum;
  logic        tx_sel;
  logic [3:0]  apb_addr;
  logic        apb_wr;
  logic [31:0] apb_wdata;
  logic        unused_prdata;

  assign apb_active = (state == S_CONF) || (state == S_MAGIC) || (state == S_HDR) ||
                      (state == S_DATA) || (state == S_ERRCLR) ||
                      (state == S_TXPOLL) || (state == S_TXWR);
  assign xfer_done  = apb_active && apb_phase && bus.apb_PREADY;
  assign rx_state   = (state == S_MAGIC) || (state == S_HDR) || (state == S_DATA);
  assign rx_byte    = bus.apb_PRDATA[7:0];
  // Empty FIFO (bit 31) means re-poll; bit 9 flags a receive error.
  assign rx_ok      = rx_state && xfer_done && !bus.apb_PRDATA[31] && !bus.apb_PRDATA[9];
  assign rx_bad     = rx_state && xfer_done && !bus.apb_PRDATA[31] &&  bus.apb_PRDATA[9];
  assign unused_prdata = ^{bus.apb_PRDATA[30:10], bus.apb_PRDATA[8]};

  assign bus.apb_PSEL    = apb_active;
  assign bus.apb_PENABLE = apb_active && apb_phase;
  assign bus.apb_PADDR   = apb_addr;
  assign bus.apb_PWRITE  = apb_wr;
  assign bus.apb_PWDATA  = apb_wdata;
  assign bus.mem_valid   = (state == S_MEMWR);
  assign bus.mem_addr    = wr_addr;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wstrb   = wstrb_q;
  assign done            = (state == S_DONE);
  assign busy            = (state != S_IDLE) && (state != S_DONE);
  assign dbg_state       = state;

  // Next-state and APB request decode.
  always_comb begin
    state_nxt = state;
    apb_addr  = 4'd0;
    apb_wr    = 1'b0;
    apb_wdata = 32'd0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CONF;
      S_CONF: begin
        apb_addr  = 4'd8;
        apb_wr    = 1'b1;
        apb_wdata = {13'b0, 3'b000, DIVISOR};
        if (xfer_done) state_nxt = S_MAGIC;
      end
      S_MAGIC, S_HDR, S_DATA: begin
        if (rx_bad) begin
          state_nxt = S_ERRCLR;
        end else if (rx_ok) begin
          if (state == S_MAGIC) begin
            if (rx_byte == MAGIC) state_nxt = S_HDR;
          end else if (state == S_HDR) begin
            if (hdr_cnt == 3'd7)
              state_nxt = ({rx_byte, hdr_len[23:0]} == 32'd0) ? S_TXPOLL : S_DATA;
          end else begin
            if ((lane == 2'd3) || (remain == 32'd1)) state_nxt = S_MEMWR;
          end
        end
      end
      S_ERRCLR: begin
        apb_wr = 1'b1;
        if (xfer_done) state_nxt = S_MAGIC;
      end
      S_MEMWR:  if (bus.mem_ready) state_nxt = (remain == 32'd0) ? S_TXPOLL : S_DATA;
      S_TXPOLL: begin
        apb_addr = 4'd4;
        if (xfer_done && !bus.apb_PRDATA[31]) state_nxt = S_TXWR;
      end
      S_TXWR: begin
        apb_addr  = 4'd4;
        apb_wr    = 1'b1;
        apb_wdata = {24'd0, (tx_sel ? csum : ACK)};
        if (xfer_done) state_nxt = tx_sel ? S_DONE : S_TXPOLL;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register, APB phase tracking and packet datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      apb_phase  <= 1'b0;
      rx_error   <= 1'b0;
      entry_addr <= 32'd0;
      hdr_cnt    <= 3'd0;
      hdr_addr   <= 32'd0;
      hdr_len    <= 32'd0;
      remain     <= 32'd0;
      wr_addr    <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      lane       <= 2'd0;
      csum       <= 8'd0;
      tx_sel     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_error <= rx_bad;
      if (!apb_active)            apb_phase <= 1'b0;
      else if (!apb_phase)        apb_phase <= 1'b1;
      else if (bus.apb_PREADY)    apb_phase <= 1'b0;

      case (state)
        S_MAGIC: if (rx_ok && (rx_byte == MAGIC)) begin
          hdr_cnt <= 3'd0;
          csum    <= 8'd0;
          tx_sel  <= 1'b0;
        end
        S_HDR: if (rx_ok) begin
          hdr_cnt <= hdr_cnt + 3'd1;
          if (hdr_cnt == 3'd0)      hdr_addr[7:0] <= {rx_byte[7:2], 2'b00};
          else if (!hdr_cnt[2])     hdr_addr[{hdr_cnt[1:0], 3'b000} +: 8] <= rx_byte;
          else                      hdr_len[{hdr_cnt[1:0], 3'b000} +: 8] <= rx_byte;
          if (hdr_cnt == 3'd7) begin
            remain  <= {rx_byte, hdr_len[23:0]};
            wr_addr <= hdr_addr;
            lane    <= 2'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
          end
        end
        S_DATA: if (rx_ok) begin
          wdata_q[{lane, 3'b000} +: 8] <= rx_byte;
          wstrb_q[lane] <= 1'b1;
          csum   <= csum + rx_byte;
          remain <= remain - 32'd1;
          lane   <= lane + 2'd1;
        end
        S_MEMWR: if (bus.mem_ready) begin
          wr_addr <= wr_addr + 32'd4;
          wdata_q <= 32'd0;
          wstrb_q <= 4'd0;
          lane    <= 2'd0;
        end
        S_TXWR: if (xfer_done) begin
          if (!tx_sel) tx_sel <= 1'b1;
          else         entry_addr <= hdr_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: UART/APB and memory slave models, directed packets,
// expected-event queue checked by a monitor.
module tb_uart_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, rx_error;
  logic [31:0] entry_addr;
  logic [3:0]  dbg_state;

  uart_loader_if bus();

  uart_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rx_error   (rx_error),
    .entry_addr (entry_addr),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  // Clock / global time limit.
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Event encoding: {type[3:0], a[31:0], b[31:0], c[3:0]}
  // 1 conf write, 2 mem write, 3 tx write, 4 done, 5 rx clear write, 6 rx_error
  logic [71:0] exp_q[$];
  logic [8:0]  rx_q[$];
  int          tx_full_cnt = 0;
  int          mem_hold = 0;
  int          apb_wait = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic score(input string name, input logic [71:0] act);
    logic [71:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected event got=%h expected=none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        bad++;
        $display("FAIL %s got=%h expected=%h", name, act, e);
      end
    end
  endtask

  // Driver tasks.
  task automatic put(input logic [7:0] b);
    rx_q.push_back({1'b0, b});
  endtask

  task automatic put_err(input logic [7:0] b);
    rx_q.push_back({1'b1, b});
  endtask

  task automatic put_hdr(input logic [31:0] a, input logic [31:0] len);
    put(8'h4C);
    for (int i = 0; i < 4; i++) put(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) put(len[8*i +: 8]);
  endtask

  task automatic exp_conf();
    exp_q.push_back({4'd1, 32'h0000_0009, 32'd0, 4'd0});
  endtask
  task automatic exp_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back({4'd2, a, d, s});
  endtask
  task automatic exp_tx(input logic [7:0] b);
    exp_q.push_back({4'd3, 24'd0, b, 36'd0});
  endtask
  task automatic exp_done(input logic [31:0] e);
    exp_q.push_back({4'd4, e, 36'd0});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // UART (APB slave) and memory responder, driven just after each rising edge.
  initial begin
    logic [8:0] e;
    bus.apb_PREADY = 1'b0;
    bus.apb_PRDATA = 32'd0;
    bus.mem_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.apb_PREADY = 1'b0;
      bus.apb_PRDATA = 32'd0;
      if (bus.apb_PSEL && !bus.apb_PENABLE) begin
        apb_wait = $urandom_range(0, 1);
      end else if (bus.apb_PSEL && bus.apb_PENABLE) begin
        if (apb_wait > 0) apb_wait--;
        else begin
          bus.apb_PREADY = 1'b1;
          if (!bus.apb_PWRITE && bus.apb_PADDR == 4'd0) begin
            if (rx_q.size() == 0) bus.apb_PRDATA = 32'h8000_0000;
            else begin
              e = rx_q.pop_front();
              bus.apb_PRDATA = {22'd0, e[8], 1'b0, e[7:0]};
            end
          end else if (!bus.apb_PWRITE && bus.apb_PADDR == 4'd4) begin
            if (tx_full_cnt > 0) begin
              bus.apb_PRDATA = 32'h8000_0000;
              tx_full_cnt--;
            end
          end
        end
      end
      if (bus.mem_valid) begin
        if (mem_hold > 0) begin
          bus.mem_ready = 1'b0;
          mem_hold--;
        end else bus.mem_ready = 1'b1;
      end else bus.mem_ready = 1'b0;
    end
  end

  // Monitor: turns DUT outputs into events and checks them against exp_q.
  initial begin
    logic        stall_prev;
    logic [67:0] mem_prev;
    stall_prev = 1'b0;
    mem_prev   = '0;
    forever begin
      @(negedge clk);
      if (reset) stall_prev = 1'b0;
      else begin
        if (bus.apb_PSEL && bus.apb_PENABLE && bus.apb_PREADY && bus.apb_PWRITE) begin
          if (bus.apb_PADDR == 4'd8)
            score("conf_write", {4'd1, bus.apb_PWDATA, 36'd0});
          else if (bus.apb_PADDR == 4'd4) begin
            score("tx_write", {4'd3, bus.apb_PWDATA, 36'd0});
            check("tx_after_full", tx_full_cnt, 0);
          end else
            score("rx_clear_write", {4'd5, 28'd0, bus.apb_PADDR, bus.apb_PWDATA, 4'd0});
        end
        if (bus.mem_valid) begin
          check("no_apb_in_memwr", {31'd0, bus.apb_PSEL}, 32'd0);
          if (stall_prev)
            check("mem_stable", {31'd0, ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} == mem_prev)}, 32'd1);
          if (bus.mem_ready) begin
            score("mem_write", {4'd2, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
            stall_prev = 1'b0;
          end else begin
            stall_prev = 1'b1;
            mem_prev   = {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
          end
        end else stall_prev = 1'b0;
        if (done)     score("done", {4'd4, entry_addr, 36'd0});
        if (rx_error) score("rx_error", {4'd6, 68'd0});
      end
    end
  end

  // Stimulus sequence and final report.
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", {31'd0, bus.apb_PSEL}, 32'd0);
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_entry", entry_addr, 32'd0);
    check("rst_state", {28'd0, dbg_state}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);

    // Two full words; a second start while busy is ignored.
    exp_conf();
    exp_mem(32'h0000_1000, 32'h4433_2211, 4'hF);
    exp_mem(32'h0000_1004, 32'h8877_6655, 4'hF);
    exp_tx(8'h4B); exp_tx(8'h64);
    exp_done(32'h0000_1000);
    pulse_start();
    put_hdr(32'h0000_1000, 32'd8);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(8'h55); put(8'h66); put(8'h77); put(8'h88);
    repeat (6) @(posedge clk);
    pulse_start();
    wait_drain("pkt_two_words");
    check("entry_two_words", entry_addr, 32'h0000_1000);

    // Garbage before magic, 3-byte partial word.
    exp_conf();
    exp_mem(32'h0000_0020, 32'h00CC_BBAA, 4'h7);
    exp_tx(8'h4B); exp_tx(8'h31);
    exp_done(32'h0000_0020);
    pulse_start();
    put(8'h00); put(8'hFF);
    put_hdr(32'h0000_0020, 32'd3);
    put(8'hAA); put(8'hBB); put(8'hCC);
    wait_drain("pkt_partial");

    // Zero length at unaligned address.
    exp_conf();
    exp_tx(8'h4B); exp_tx(8'h00);
    exp_done(32'h0000_1000);
    pulse_start();
    put_hdr(32'h0000_1003, 32'd0);
    wait_drain("pkt_len0");
    check("entry_len0", entry_addr, 32'h0000_1000);

    // Receive error in header byte 2, then a good packet.
    exp_conf();
    exp_q.push_back({4'd6, 68'd0});
    exp_q.push_back({4'd5, 32'd0, 32'd0, 4'd0});
    exp_mem(32'h0000_0040, 32'h0403_0201, 4'hF);
    exp_tx(8'h4B); exp_tx(8'h0A);
    exp_done(32'h0000_0040);
    pulse_start();
    put(8'h4C); put(8'h00); put_err(8'h10);
    put_hdr(32'h0000_0040, 32'd4);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    wait_drain("pkt_rx_err");

    // Memory back-pressure and transmitter full.
    mem_hold = 10;
    tx_full_cnt = 5;
    exp_conf();
    exp_mem(32'h0000_0100, 32'hEFBE_ADDE, 4'hF);
    exp_tx(8'h4B); exp_tx(8'h38);
    exp_done(32'h0000_0100);
    pulse_start();
    put_hdr(32'h0000_0100, 32'd4);
    put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
    wait_drain("pkt_stall");
    check("tx_full_consumed", tx_full_cnt, 0);

    // Reset while in DATA, then restart.
    exp_conf();
    pulse_start();
    put_hdr(32'h0000_0200, 32'd8);
    put(8'h11); put(8'h22);
    n = 0;
    while (!(dbg_state == 4'd4 && rx_q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_data", {31'd0, (dbg_state == 4'd4)}, 32'd1);
    repeat (3) @(negedge clk);
    check("conf_before_reset", exp_q.size(), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("mid_rst_psel", {31'd0, bus.apb_PSEL}, 32'd0);
    check("mid_rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_entry", entry_addr, 32'd0);
    rx_q.delete();
    exp_conf();
    exp_mem(32'h0000_0300, 32'h0000_0201, 4'h3);
    exp_tx(8'h4B); exp_tx(8'h03);
    exp_done(32'h0000_0300);
    pulse_start();
    put_hdr(32'h0000_0300, 32'd2);
    put(8'h01); put(8'h02);
    wait_drain("pkt_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time APB master that sits directly upstream of the UART controller on its APB port and consumes the bytes it receives. On `start` it programs the UART divisor, hunts for a framed load packet (magic byte, 32-bit address, 32-bit length, payload), writes the payload into memory as 32-bit words, and replies with an acknowledge byte plus checksum through the UART transmitter. It hands the load address to the boot sequencer as the entry point.

## Interface
Parameters:
- `DIVISOR`, 16'd9: value written to the UART conf register (bits 15:0; bits 18:16 written 0: no parity, 1 stop bit).
- `MAGIC`, 8'h4C: packet start byte.
- `ACK`, 8'h4B: reply byte sent before the checksum.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a load when idle.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the ACK and checksum are queued.
- `rx_error`  out  1  one-cycle pulse per UART receive error seen.
- `entry_addr`  out  32  word-aligned load address of the last completed packet.
- `apb_PADDR`  out  4  UART register address: 0 receiver, 4 transmitter, 8 conf.
- `apb_PSEL`, `apb_PENABLE`, `apb_PWRITE`  out  1 each  APB master controls.
- `apb_PWDATA`  out  32  write data.
- `apb_PREADY`  in  1  slave ready.
- `apb_PRDATA`  in  32  slave read data.
- `mem_valid`  out  1  memory write request.
- `mem_ready`  in  1  memory accepts the request when `mem_valid & mem_ready`.
- `mem_addr`  out  32  byte address, bits 1:0 always 0.
- `mem_wdata`  out  32  little-endian word.
- `mem_wstrb`  out  4  byte enables.

## Operation
- States: IDLE, CONF, MAGIC, HDR, DATA, MEMWR, TXPOLL, TXWR, DONE.
- IDLE → CONF on `start`. A `start` pulse while busy is ignored.
- CONF: one APB write to address 8 with `{13'b0, 3'b000, DIVISOR}`, then → MAGIC.
- Byte receive is an APB read of address 0 and is shared by MAGIC, HDR and DATA:
  - PRDATA[31]=1 means the FIFO is empty; re-poll.
  - Otherwise the byte is PRDATA[7:0]. A non-empty read pops exactly one byte.
  - PRDATA[9]=1 (rx_err): pulse `rx_error`, issue an APB write to address 0 to clear it, discard the byte, and return to MAGIC. All header, data and checksum progress is lost.
- MAGIC: discard bytes until one equals `MAGIC`, then → HDR with the byte counter set to 0.
- HDR: 8 bytes. Bytes 0–3 form the address and bytes 4–7 the length, both little-endian.
  - Address bits 1:0 are forced to 0.
  - Length 0 → TXPOLL; otherwise → DATA.
- DATA: each byte is placed in lane `k mod 4`, where k is the payload byte index, and its strobe bit is set. The checksum is the 8-bit sum of payload bytes, modulo 256.
  - Go to MEMWR after 4 bytes, or after the last byte (partial word: only received lanes are strobed, other lanes 0).
- MEMWR: hold `mem_valid` and all `mem_*` signals stable until `mem_ready`.
  - Then address += 4 (wraps modulo 2^32) and the strobes clear.
  - Remaining length > 0 → DATA; otherwise → TXPOLL.
  - No UART polling occurs while in MEMWR.
- TXPOLL / TXWR: for each of `ACK` then the checksum, do the following:
  - Read address 4 until PRDATA[31] (tx_full) = 0.
  - Then write the byte (PWDATA[7:0], upper bits 0) to address 4.
- DONE: update `entry_addr` to the header address, pulse `done`, drop `busy`, → IDLE.

## Timing
- APB transfer: setup cycle (PSEL=1, PENABLE=0), then access cycles (PENABLE=1) until PREADY=1. PRDATA is sampled on the cycle PREADY=1.
- The next setup may start in the cycle after completion; minimum 2 cycles per transfer.
- PADDR, PWRITE and PWDATA are stable from setup through completion.
- PSEL=0 and PENABLE=0 in IDLE, MEMWR and DONE.
- Payload throughput: one byte per 2 cycles when the FIFO holds data. MEMWR adds ≥1 cycle per word.
- `done` is asserted the cycle after the checksum write completes. `busy` falls in the same cycle.
- Reset values: all outputs 0, including `entry_addr`; state IDLE.
- Reset mid-transfer abandons any APB or memory transaction immediately: PSEL and `mem_valid` are low the cycle after reset is sampled.
- A length ≥ 2^32−1 is accepted. The loader simply runs until the count reaches 0.

## Test plan
- Stream 4C 00 10 00 00 08 00 00 00 11 22 33 44 55 66 77 88 → two memory writes:
  - 0x00001000 / 0x44332211 / 1111
  - 0x00001004 / 0x88776655 / 1111
  - Then TX bytes 4B, 64; `entry_addr`=0x00001000; `done` pulses once.
- Garbage 00 FF before the magic, and a 3-byte payload AA BB CC at 0x20 → one write of 0x00CCBBAA, strobe 0111, TX 4B 31.
- Length 0 at address 0x00001003 → no memory writes, TX 4B 00, `entry_addr`=0x00001000.
- rx_err set during byte 2 of the header → `rx_error` pulse, clearing APB write to address 0, re-hunt. A following valid packet completes normally.
- Hold `mem_ready`=0 for 10 cycles, and tx_full=1 for 5 polls → `mem_*` stable throughout, no APB activity during MEMWR, TX write issued only after tx_full clears.
- Assert `reset` mid-DATA → next cycle PSEL=0, `mem_valid`=0, `busy`=0. A new `start` restarts with the CONF write (PWDATA=0x00000009).
